// File: rtl/mipi_rx_lane_aligner.sv
// D-PHY HS receive aligner: per-lane sync hunt and bit alignment, per-lane
// deskew FIFOs, and a burst FSM merging all enabled lanes into one word.

module mipi_rx_lane_aligner_lane #(
    parameter logic [7:0] SYNC_BYTE = 8'hB8,
    parameter int         DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       hunt,
    input  logic       run,
    input  logic       pop,
    input  logic       flush,
    output logic       locked,
    output logic [7:0] head,
    output logic       nonempty,
    output logic       overflow
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [7:0]      prev;
    logic [15:0]     window;
    logic [2:0]      offset;
    logic [2:0]      match_k;
    logic            match;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CNTW-1:0] count;
    logic            push;
    logic            full;
    logic            wr;
    logic            rd;

    assign window = {byte_in, prev};

    // Descending scan so the lowest matching offset is the one kept.
    always_comb begin
        match   = 1'b0;
        match_k = '0;
        for (int k = 7; k >= 0; k--) begin
            if (window[k +: 8] == SYNC_BYTE) begin
                match   = 1'b1;
                match_k = 3'(k);
            end
        end
    end

    assign push     = run && locked;
    assign full     = (count == CNTW'(DEPTH));
    assign rd       = pop && nonempty;
    assign overflow = push && full && !rd;
    assign wr       = push && (!full || rd);
    assign head     = mem[rptr];
    assign nonempty = (count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev   <= '0;
            locked <= 1'b0;
            offset <= '0;
        end else begin
            prev <= byte_in;
            if (flush) begin
                locked <= 1'b0;
                offset <= '0;
            end else if (hunt && !locked && match) begin
                locked <= 1'b1;
                offset <= match_k;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                mem[wptr] <= window[offset +: 8];
                wptr      <= wptr + AW'(1);
            end
            if (rd) rptr <= rptr + AW'(1);
            count <= count + CNTW'(wr) - CNTW'(rd);
        end
    end
endmodule

module mipi_rx_lane_aligner #(
    parameter int         NUM_LANES    = 4,
    parameter logic [7:0] SYNC_BYTE    = 8'hB8,
    parameter int         DESKEW_DEPTH = 4,
    parameter int         SYNC_TIMEOUT = 16
) (
    input  logic                   HS_BYTE_CLK,
    input  logic                   RST,
    input  logic [NUM_LANES-1:0]   LANE_EN,
    input  logic [NUM_LANES-1:0]   HS_ACTIVE,
    input  logic [NUM_LANES*8-1:0] BYTE_IN,
    output logic [NUM_LANES-1:0]   LANE_SYNC,
    output logic [NUM_LANES*8-1:0] DATA_OUT,
    output logic                   DATA_VALID,
    output logic                   SOT,
    output logic                   EOT,
    output logic                   ERR_SYNC,
    output logic                   ERR_SKEW
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HUNT    = 2'd1;
    localparam logic [1:0] S_ALIGNED = 2'd2;
    localparam logic [1:0] S_ERR     = 2'd3;
    localparam int         CW        = $clog2(SYNC_TIMEOUT + 1);

    logic [1:0]                  state;
    logic [CW-1:0]               sync_cnt;
    logic [NUM_LANES-1:0]        locked;
    logic [NUM_LANES-1:0]        nonempty;
    logic [NUM_LANES-1:0]        overflow;
    logic [NUM_LANES-1:0][7:0]   head;
    logic [NUM_LANES*8-1:0]      merged;
    logic any_en, hs_all, eob, all_locked, any_locked, all_ready;
    logic skew_err, pop, timeout, sot_seen;

    assign any_en     = |LANE_EN;
    assign hs_all     = any_en && ((HS_ACTIVE & LANE_EN) == LANE_EN);
    assign eob        = (state != S_IDLE) && |(LANE_EN & ~HS_ACTIVE);
    assign all_locked = any_en && ((locked & LANE_EN) == LANE_EN);
    assign any_locked = |(locked & LANE_EN);
    assign all_ready  = any_en && &(nonempty | ~LANE_EN);
    assign skew_err   = |(overflow & LANE_EN);
    assign pop        = (state == S_ALIGNED) && all_ready && !eob;
    assign timeout    = any_locked && !all_locked && (sync_cnt == CW'(SYNC_TIMEOUT - 1));
    assign LANE_SYNC  = locked & LANE_EN;

    // Disabled lanes are held flushed so they never lock or hold data.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        mipi_rx_lane_aligner_lane #(
            .SYNC_BYTE(SYNC_BYTE),
            .DEPTH    (DESKEW_DEPTH)
        ) u_lane (
            .clk     (HS_BYTE_CLK),
            .rst     (RST),
            .byte_in (BYTE_IN[8*i +: 8]),
            .hunt    (LANE_EN[i] && (state == S_HUNT)),
            .run     (LANE_EN[i] && ((state == S_HUNT) || (state == S_ALIGNED)) && !eob),
            .pop     (pop && LANE_EN[i]),
            .flush   ((state == S_IDLE) || eob || !LANE_EN[i]),
            .locked  (locked[i]),
            .head    (head[i]),
            .nonempty(nonempty[i]),
            .overflow(overflow[i])
        );
        assign merged[8*i +: 8] = LANE_EN[i] ? head[i] : 8'h00;
    end

    always_ff @(posedge HS_BYTE_CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            sync_cnt   <= '0;
            sot_seen   <= 1'b0;
            DATA_OUT   <= '0;
            DATA_VALID <= 1'b0;
            SOT        <= 1'b0;
            EOT        <= 1'b0;
            ERR_SYNC   <= 1'b0;
            ERR_SKEW   <= 1'b0;
        end else begin
            EOT        <= 1'b0;
            DATA_VALID <= pop;
            SOT        <= pop && !sot_seen;
            DATA_OUT   <= pop ? merged : '0;
            if (pop) sot_seen <= 1'b1;
            if ((state == S_HUNT) && any_locked && (sync_cnt != CW'(SYNC_TIMEOUT)))
                sync_cnt <= sync_cnt + CW'(1);
            if (eob) begin
                state    <= S_IDLE;
                EOT      <= (state == S_ALIGNED);
                ERR_SYNC <= 1'b0;
                ERR_SKEW <= 1'b0;
                sync_cnt <= '0;
                sot_seen <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (hs_all) state <= S_HUNT;
                    S_HUNT: begin
                        if (skew_err) begin
                            state    <= S_ERR;
                            ERR_SKEW <= 1'b1;
                        end else if (all_locked) begin
                            state <= S_ALIGNED;
                        end else if (timeout) begin
                            state    <= S_ERR;
                            ERR_SYNC <= 1'b1;
                        end
                    end
                    S_ALIGNED: begin
                        if (skew_err) begin
                            state    <= S_ERR;
                            ERR_SKEW <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mipi_rx_lane_aligner.sv
// Directed bench: stimulus pushes expected words to a scoreboard, a negedge
// monitor pops them whenever DATA_VALID is seen.
module tb_mipi_rx_lane_aligner;
    localparam int P = 2;  // idle bytes before the sync on an unskewed lane

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  lane_en;
    logic [3:0]  hs_active;
    logic [31:0] byte_in;
    logic [3:0]  lane_sync, lane_sync2;
    logic [31:0] data_out, data_out2;
    logic        data_valid, sot, eot, err_sync, err_skew;
    logic        data_valid2, sot2, eot2, err_sync2, err_skew2;

    always #5 clk = ~clk;

    mipi_rx_lane_aligner dut (
        .HS_BYTE_CLK(clk), .RST(rst), .LANE_EN(lane_en), .HS_ACTIVE(hs_active),
        .BYTE_IN(byte_in), .LANE_SYNC(lane_sync), .DATA_OUT(data_out),
        .DATA_VALID(data_valid), .SOT(sot), .EOT(eot), .ERR_SYNC(err_sync), .ERR_SKEW(err_skew)
    );

    // Deep FIFOs keep overflow out of the way so the sync timeout can be seen.
    mipi_rx_lane_aligner #(.DESKEW_DEPTH(32)) dut2 (
        .HS_BYTE_CLK(clk), .RST(rst), .LANE_EN(lane_en), .HS_ACTIVE(hs_active),
        .BYTE_IN(byte_in), .LANE_SYNC(lane_sync2), .DATA_OUT(data_out2),
        .DATA_VALID(data_valid2), .SOT(sot2), .EOT(eot2), .ERR_SYNC(err_sync2), .ERR_SKEW(err_skew2)
    );

    typedef struct packed { logic [31:0] data; logic sot; } exp_t;
    exp_t sb[$];
    int total = 0;
    int bad   = 0;
    int dly[4];
    int hs_end[4];
    logic [3:0] tx_sync;
    int v2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && data_valid) begin
            exp_t e;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got %h want no word", data_out);
            end else begin
                e = sb.pop_front();
                chk("data_out", data_out, e.data);
                chk("sot", {31'd0, sot}, {31'd0, e.sot});
            end
        end
    end

    // Wire bitstream: zeros, sync at bit 8*(P+dly)+3, payload bytes 1..16, zeros.
    function automatic logic [7:0] lane_byte(input int i, input int n);
        logic [7:0] b, sync, pl;
        int base, r;
        sync = 8'hB8;
        b    = '0;
        base = 8 * (P + dly[i]) + 3;
        for (int k = 0; k < 8; k++) begin
            r = 8 * n + k - base;
            if (r >= 0 && r < 8) begin
                b[k] = tx_sync[i] ? sync[r] : 1'b0;
            end else if (r >= 8 && r < 136) begin
                pl   = 8'((r - 8) / 8 + 1);
                b[k] = pl[(r - 8) % 8];
            end
        end
        return b;
    endfunction

    task automatic drive(input int n);
        for (int i = 0; i < 4; i++) begin
            hs_active[i]     = (n >= 1 && n < hs_end[i]);
            byte_in[8*i +: 8] = lane_en[i] ? lane_byte(i, n) : 8'($urandom);
        end
    endtask

    task automatic idle(input int k);
        for (int c = 0; c < k; c++) begin
            @(posedge clk); #1;
            hs_active = '0;
            byte_in   = '0;
        end
    endtask

    task automatic push_words(input int last, input logic [3:0] mask);
        exp_t e;
        for (int j = 1; j <= last; j++) begin
            e.data = '0;
            for (int i = 0; i < 4; i++) if (mask[i]) e.data[8*i +: 8] = 8'(j);
            e.sot = (j == 1);
            sb.push_back(e);
        end
    endtask

    task automatic end_test(input string name);
        chk(name, sb.size(), 0);
        sb.delete();
    endtask

    task automatic run(input int tid, input int ncyc);
        for (int n = 0; n < ncyc; n++) begin
            @(posedge clk); #1;
            drive(n);
            #1;
            case (tid)
                1: begin
                    if (n == 3)  chk("t1_sync_early", lane_sync, 4'h0);
                    if (n == 4)  chk("t1_sync", lane_sync, 4'hF);
                    if (n == 5)  chk("t1_valid_early", data_valid, 0);
                    if (n == 6)  chk("t1_valid_sot", {data_valid, sot}, 2'b11);
                    if (n == 20) chk("t1_no_err", {err_sync, err_skew}, 0);
                    if (n == 22) chk("t1_eot", {eot, data_valid}, 2'b10);
                    if (n == 23) chk("t1_eot_end", eot, 0);
                end
                2: begin
                    if (n == 6)  chk("t2_sync_partial", lane_sync, 4'h7);
                    if (n == 7)  chk("t2_sync", lane_sync, 4'hF);
                    if (n == 8)  chk("t2_valid_early", data_valid, 0);
                    if (n == 9)  chk("t2_valid", data_valid, 1);
                    if (n == 23) chk("t2_no_skew_err", err_skew, 0);
                    if (n == 25) chk("t2_eot", eot, 1);
                end
                3: begin
                    if (n == 8)  chk("t3_skew_early", err_skew, 0);
                    if (n == 9)  chk("t3_skew", err_skew, 1);
                    if (n == 13) chk("t3_skew_held", {err_skew, err_sync}, 2'b10);
                    if (n == 15) chk("t3_cleared", {lane_sync, err_skew, eot}, 0);
                end
                4: begin
                    if (data_valid2) v2++;
                    if (n == 4)  chk("t4_sync", lane_sync2, 4'hB);
                    if (n == 9)  chk("t4_main_skew", err_skew, 1);
                    if (n == 19) chk("t4_sync_err_early", err_sync2, 0);
                    if (n == 20) chk("t4_sync_err", err_sync2, 1);
                    if (n == 23) chk("t4_sync_err_held", {err_sync2, err_skew2}, 2'b10);
                    if (n == 25) chk("t4_cleared", err_sync2, 0);
                end
                5: begin
                    if (n == 4)  chk("t5_sync", lane_sync, 4'h3);
                    if (n == 22) chk("t5_eot", eot, 1);
                end
                6: begin
                    if (n == 12) chk("t6_pre_eot", {eot, data_valid}, 2'b01);
                    if (n == 13) chk("t6_eot", {eot, data_valid, lane_sync}, 6'b100000);
                    if (n == 14) chk("t6_eot_end", eot, 0);
                end
                7: begin
                    if (n == 10) begin
                        rst = 1'b1;
                        #1;
                        chk("t7_rst_data", data_out, 0);
                        chk("t7_rst_flags", {lane_sync, data_valid, sot, eot, err_sync, err_skew}, 0);
                    end
                    if (n == 11) rst = 1'b0;
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        lane_en   = 4'hF;
        hs_active = '0;
        byte_in   = '0;
        tx_sync   = 4'hF;
        dly       = '{0, 0, 0, 0};
        hs_end    = '{0, 0, 0, 0};
        v2        = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data", data_out, 0);
        chk("reset_flags", {lane_sync, data_valid, sot, eot, err_sync, err_skew}, 0);
        rst = 1'b0;
        idle(3);

        hs_end = '{21, 21, 21, 21};
        push_words(16, 4'hF);
        run(1, 25);
        end_test("t1_drained");
        idle(4);

        dly    = '{0, 1, 2, 3};
        hs_end = '{24, 24, 24, 24};
        push_words(16, 4'hF);
        run(2, 28);
        end_test("t2_drained");
        idle(4);

        dly    = '{0, 0, 0, 5};
        hs_end = '{14, 14, 14, 14};
        run(3, 18);
        end_test("t3_drained");
        idle(4);

        dly     = '{0, 0, 0, 0};
        tx_sync = 4'b1011;
        hs_end  = '{24, 24, 24, 24};
        run(4, 28);
        chk("t4_no_valid", v2, 0);
        end_test("t4_drained");
        tx_sync = 4'hF;
        idle(4);

        lane_en = 4'b0011;
        hs_end  = '{21, 21, 0, 0};
        push_words(16, 4'b0011);
        run(5, 25);
        end_test("t5_drained");
        idle(4);
        lane_en = 4'hF;
        idle(2);

        hs_end = '{12, 40, 40, 40};
        push_words(7, 4'hF);
        run(6, 18);
        end_test("t6_drained");
        idle(4);

        hs_end = '{40, 40, 40, 40};
        push_words(4, 4'hF);
        run(7, 16);
        end_test("t7_drained");
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
